// File: rtl/vpu_sram_rd_arb_if.sv
// Bundle of the requester-side handshake and the SRAM read-port signals
// handled by the shared SRAM read arbiter.
interface vpu_sram_rd_arb_if #(
  parameter int REQ_CNT    = 3,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 256
);
  logic [REQ_CNT-1:0]            req_i;
  logic [REQ_CNT*ADDR_WIDTH-1:0] addr_i;
  logic [REQ_CNT-1:0]            ack_o;
  logic [REQ_CNT-1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0]         rdata_o;
  logic                          sram_rden_o;
  logic [ADDR_WIDTH-1:0]         sram_addr_o;
  logic                          sram_rvalid_i;
  logic [DATA_WIDTH-1:0]         sram_rdata_i;
  logic                          busy_o;
  logic                          err_o;

  // Arbiter side
  modport slave (
    input  req_i, addr_i, sram_rvalid_i, sram_rdata_i,
    output ack_o, rvalid_o, rdata_o, sram_rden_o, sram_addr_o, busy_o, err_o
  );

  // Requester / SRAM side
  modport master (
    output req_i, addr_i, sram_rvalid_i, sram_rdata_i,
    input  ack_o, rvalid_o, rdata_o, sram_rden_o, sram_addr_o, busy_o, err_o
  );
endinterface

// File: rtl/vpu_sram_rd_arb.sv
// Round-robin arbiter sharing one SRAM read port among REQ_CNT source-port
// controllers. Issued requester indices go into an in-order tag FIFO so each
// returned beat is routed back to the requester that asked for it.
module vpu_sram_rd_arb #(
  parameter int REQ_CNT         = 3,
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst,
  vpu_sram_rd_arb_if.slave bus
);
  localparam int TAG_W = $clog2(REQ_CNT);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(REQ_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

  logic [TAG_W-1:0]      rr_ptr;
  logic [TAG_W-1:0]      winner;
  logic [TAG_W-1:0]      cand;
  logic                  found;
  logic                  grant;
  logic                  pop;
  logic                  spurious;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [TAG_W-1:0]      tag_mem [MAX_OUTSTANDING];
  logic [REQ_CNT-1:0]    rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  // Search for the first pending request starting at the round-robin pointer
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int i = 0; i < REQ_CNT; i++) begin
      if (!found && bus.req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = (cand == LAST_REQ) ? '0 : cand + 1'b1;
    end
  end

  // Grant, return pop and spurious-return detection; reset masks the grant
  always_comb begin
    grant    = !rst && found && (count != CNT_FULL);
    win_addr = bus.addr_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
    pop      = bus.sram_rvalid_i && (count != '0);
    spurious = bus.sram_rvalid_i && (count == '0);
  end

  // Drive the handshake and SRAM port; the address holds when idle
  always_comb begin
    bus.ack_o       = grant ? (REQ_CNT'(1) << winner) : '0;
    bus.sram_rden_o = grant;
    bus.sram_addr_o = grant ? win_addr : addr_q;
    bus.rvalid_o    = rvalid_q;
    bus.rdata_o     = rdata_q;
    bus.busy_o      = (count != '0) || (|rvalid_q);
    bus.err_o       = err_q;
  end

  // Tag storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    if (grant) begin
      tag_mem[wr_ptr] <= winner;
    end
  end

  // Pointer, FIFO occupancy, registered return and sticky error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      addr_q   <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (grant) begin
        rr_ptr <= (winner == LAST_REQ) ? '0 : winner + 1'b1;
        addr_q <= win_addr;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        rvalid_q <= REQ_CNT'(1) << tag_mem[rd_ptr];
        rdata_q  <= bus.sram_rdata_i;
      end else begin
        rvalid_q <= '0;
      end
      if (grant && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !grant) begin
        count <= count - 1'b1;
      end
      if (spurious) begin
        err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vpu_sram_rd_arb.sv
// Directed bench for the SRAM read arbiter: an SRAM model with configurable
// latency, a reference arbiter model and a return-data scoreboard.
module tb_vpu_sram_rd_arb;
  localparam int REQ_CNT    = 3;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 256;
  localparam int MAX_OUT    = 4;

  typedef struct {
    logic [REQ_CNT-1:0]    onehot;
    logic [DATA_WIDTH-1:0] data;
    int                    issue;
    int                    lat;
  } exp_t;

  typedef struct {
    int                    due;
    logic [DATA_WIDTH-1:0] data;
  } ret_t;

  logic clk = 1'b0;
  logic rst;

  vpu_sram_rd_arb_if #(.REQ_CNT(REQ_CNT), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  vpu_sram_rd_arb #(
    .REQ_CNT(REQ_CNT), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  exp_t                  sb[$];
  ret_t                  sram_q[$];
  int                    vectors;
  int                    miscompares;
  int                    cyc;
  int                    latency;
  int                    seq;
  int                    m_ptr;
  int                    m_count;
  bit                    m_err;
  bit                    pend;
  exp_t                  pend_e;
  bit                    spurious_now;
  logic [ADDR_WIDTH-1:0] addrs [REQ_CNT];
  logic [REQ_CNT-1:0]    ack_seen;
  logic [REQ_CNT-1:0]    got [10];
  logic [REQ_CNT-1:0]    want_seq [10];

  function automatic logic [DATA_WIDTH-1:0] data_of(input logic [ADDR_WIDTH-1:0] a, input int s);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < DATA_WIDTH / 32; i++) begin
      d[i*32 +: 32] = {a, 16'(s * 8 + i)};
    end
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_WIDTH-1:0] obs,
                             input logic [DATA_WIDTH-1:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One clock cycle: drive requests and SRAM return, check outputs, advance models
  task automatic applyStimulus(input logic [REQ_CNT-1:0] req, output logic [REQ_CNT-1:0] ack);
    logic                  rv;
    logic [DATA_WIDTH-1:0] rd;
    bit                    elig;
    bit                    pop;
    int                    win;
    logic [REQ_CNT-1:0]    want_ack;
    logic [DATA_WIDTH-1:0] d;
    while (sram_q.size() > 0 && sram_q[0].due < cyc) void'(sram_q.pop_front());
    bus.req_i = req;
    for (int k = 0; k < REQ_CNT; k++) bus.addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] = addrs[k];
    rv = 1'b0;
    rd = '0;
    if (sram_q.size() > 0 && sram_q[0].due == cyc) begin
      rv = 1'b1;
      rd = sram_q[0].data;
      void'(sram_q.pop_front());
    end else if (spurious_now) begin
      rv = 1'b1;
      rd = data_of(16'hDEAD, 99);
    end
    bus.sram_rvalid_i = rv;
    bus.sram_rdata_i  = rd;
    @(negedge clk);
    elig = (req != '0) && (m_count < MAX_OUT);
    win  = -1;
    for (int i = 0; i < REQ_CNT; i++) begin
      int c;
      c = (m_ptr + i) % REQ_CNT;
      if (win < 0 && req[c]) win = c;
    end
    want_ack = elig ? (REQ_CNT'(1) << win) : '0;
    checkOutput("ack_o", bus.ack_o, want_ack);
    checkOutput("sram_rden_o", bus.sram_rden_o, elig);
    if (elig) checkOutput("sram_addr_o", bus.sram_addr_o, addrs[win]);
    checkOutput("rvalid_o", bus.rvalid_o, pend ? pend_e.onehot : '0);
    if (pend) begin
      checkOutput("rdata_o", bus.rdata_o, pend_e.data);
      checkOutput("return_latency", cyc - pend_e.issue, pend_e.lat + 1);
    end
    checkOutput("busy_o", bus.busy_o, (m_count != 0) || pend);
    checkOutput("err_o", bus.err_o, m_err);
    ack = bus.ack_o;
    pop = rv && (m_count != 0);
    if (rv && m_count == 0) m_err = 1'b1;
    pend = 1'b0;
    if (pop) begin
      pend_e = sb.pop_front();
      pend   = 1'b1;
    end
    if (elig) begin
      d = data_of(addrs[win], seq);
      seq++;
      sb.push_back('{REQ_CNT'(1) << win, d, cyc, latency});
      sram_q.push_back('{cyc + latency, d});
      m_ptr = (win + 1) % REQ_CNT;
    end
    m_count = m_count + int'(elig) - int'(pop);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max_cycles);
    logic [REQ_CNT-1:0] a;
    int n;
    n = 0;
    while (n < max_cycles && !(sb.size() == 0 && sram_q.size() == 0 && !pend)) begin
      applyStimulus('0, a);
      n++;
    end
    checkOutput("drain_done", (sb.size() == 0 && sram_q.size() == 0 && !pend), 1'b1);
  endtask

  task automatic clearModel();
    m_ptr   = 0;
    m_count = 0;
    m_err   = 1'b0;
    pend    = 1'b0;
    sb.delete();
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    bus.sram_rvalid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    clearModel();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; seq = 0; latency = 1;
    spurious_now = 1'b0;
    clearModel();
    for (int k = 0; k < REQ_CNT; k++) addrs[k] = '0;
    rst = 1'b1;
    bus.req_i = '0; bus.addr_i = '0;
    bus.sram_rvalid_i = 1'b0; bus.sram_rdata_i = '0;
    #1;
    checkOutput("rst_ack_o", bus.ack_o, '0);
    checkOutput("rst_rvalid_o", bus.rvalid_o, '0);
    checkOutput("rst_rdata_o", bus.rdata_o, '0);
    checkOutput("rst_sram_rden_o", bus.sram_rden_o, '0);
    checkOutput("rst_sram_addr_o", bus.sram_addr_o, '0);
    checkOutput("rst_busy_o", bus.busy_o, '0);
    checkOutput("rst_err_o", bus.err_o, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] single request");
    latency = 2;
    addrs[1] = 16'h0040;
    applyStimulus(3'b010, ack_seen);
    checkOutput("t1_ack", ack_seen, 3'b010);
    drain(16);

    $display("[TB] round robin");
    pulseReset();
    latency = 1;
    addrs[0] = 16'h0010; addrs[1] = 16'h0020; addrs[2] = 16'h0030;
    want_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) applyStimulus(3'b111, got[i]);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("t2_grant%0d", i), got[i], want_seq[i]);
    drain(16);

    $display("[TB] full");
    latency = 8;
    want_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 0, 0, 0, 0, 0, 3'b001};
    for (int i = 0; i < 10; i++) applyStimulus(3'b001, got[i]);
    for (int i = 0; i < 10; i++) checkOutput($sformatf("t3_grant%0d", i), got[i], want_seq[i]);
    drain(40);

    $display("[TB] simultaneous push and pop");
    latency = 2;
    want_seq = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) applyStimulus(3'b011, got[i]);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("t4_grant%0d", i), got[i], want_seq[i]);
    drain(16);

    $display("[TB] spurious return");
    spurious_now = 1'b1;
    applyStimulus('0, ack_seen);
    spurious_now = 1'b0;
    checkOutput("t5_err_set", bus.err_o, 1'b1);
    applyStimulus('0, ack_seen);
    applyStimulus('0, ack_seen);
    checkOutput("t5_err_sticky", bus.err_o, 1'b1);
    checkOutput("t5_rvalid", bus.rvalid_o, '0);

    $display("[TB] async reset with reads in flight");
    latency = 8;
    for (int i = 0; i < 3; i++) applyStimulus(3'b111, ack_seen);
    bus.req_i = 3'b111;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_ack_o", bus.ack_o, '0);
    checkOutput("t6_rvalid_o", bus.rvalid_o, '0);
    checkOutput("t6_rdata_o", bus.rdata_o, '0);
    checkOutput("t6_sram_rden_o", bus.sram_rden_o, '0);
    checkOutput("t6_sram_addr_o", bus.sram_addr_o, '0);
    checkOutput("t6_busy_o", bus.busy_o, '0);
    checkOutput("t6_err_o", bus.err_o, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    clearModel();
    drain(20);
    checkOutput("t6_stale_err", bus.err_o, 1'b1);
    latency = 1;
    applyStimulus(3'b111, ack_seen);
    checkOutput("t6_first_grant", ack_seen, 3'b001);
    drain(16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
